// File: rtl/c_gate_bus_split_v4_0.sv
// Round-robin bus splitter: each accepted input word goes to the lane at the
// pointer, XORed with that lane's inversion mask, and is held there until the
// lane consumer acknowledges it. A full lane at the pointer stalls the stream.

// One output lane: a one-word holding register plus its valid flag.
module c_gate_bus_split_v4_0_lane #(
    parameter int                 W    = 16,
    parameter logic [W-1:0]       MASK = '0,
    parameter logic [W-1:0]       INIT = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         ce,
    input  logic         load,
    input  logic         ack,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         v
);
    // Written as expressions rather than if/else so an X on load/ack reaches
    // q and v instead of silently taking one branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= INIT;
            v <= 1'b0;
        end else if (clr) begin
            q <= INIT;
            v <= 1'b0;
        end else if (ce) begin
            v <= load | (v & ~ack);
            q <= load ? (d ^ MASK) : q;
        end
    end
endmodule

module c_gate_bus_split_v4_0 #(
    parameter int                     C_WIDTH             = 16,
    parameter int                     C_OUTPUTS           = 4,
    parameter logic [8*C_WIDTH-1:0]   C_OUTPUT_A_INV_MASK = "",
    parameter logic [8*C_WIDTH-1:0]   C_OUTPUT_B_INV_MASK = "",
    parameter logic [8*C_WIDTH-1:0]   C_OUTPUT_C_INV_MASK = "",
    parameter logic [8*C_WIDTH-1:0]   C_OUTPUT_D_INV_MASK = "",
    parameter logic [8*C_WIDTH-1:0]   C_AINIT_VAL         = "",
    parameter int                     C_HAS_CE            = 0,
    parameter int                     C_HAS_SCLR          = 0,
    parameter int                     C_SYNC_ENABLE       = 0
) (
    input  logic               CLK,
    input  logic               ACLR,
    input  logic               CE,
    input  logic               SCLR,
    input  logic [C_WIDTH-1:0] D,
    input  logic               ND,
    output logic               RFD,
    output logic [C_WIDTH-1:0] QA,
    output logic [C_WIDTH-1:0] QB,
    output logic [C_WIDTH-1:0] QC,
    output logic [C_WIDTH-1:0] QD,
    output logic               VA,
    output logic               VB,
    output logic               VC,
    output logic               VD,
    input  logic               ACKA,
    input  logic               ACKB,
    input  logic               ACKC,
    input  logic               ACKD,
    output logic [1:0]         LANE
);
    localparam int NUM_LANES = 4;

    // Strings are packed MSB-first, so byte b of the literal is result bit b.
    function automatic logic [C_WIDTH-1:0] parse_bits(input logic [8*C_WIDTH-1:0] s);
        logic [C_WIDTH-1:0] r;
        r = '0;
        for (int b = 0; b < C_WIDTH; b++) r[b] = (s[8*b +: 8] == 8'h31);
        return r;
    endfunction

    // Only '0', '1' and NUL (short or empty string) are legal characters.
    function automatic bit str_ok(input logic [8*C_WIDTH-1:0] s);
        bit ok;
        ok = 1'b1;
        for (int b = 0; b < C_WIDTH; b++)
            if (!(s[8*b +: 8] inside {8'h00, 8'h30, 8'h31})) ok = 1'b0;
        return ok;
    endfunction

    if (!(str_ok(C_OUTPUT_A_INV_MASK) && str_ok(C_OUTPUT_B_INV_MASK) &&
          str_ok(C_OUTPUT_C_INV_MASK) && str_ok(C_OUTPUT_D_INV_MASK) &&
          str_ok(C_AINIT_VAL))) begin : g_bad_str
        $fatal(1, "c_gate_bus_split_v4_0: illegal character in mask/init string");
    end
    if (C_OUTPUTS < 2 || C_OUTPUTS > NUM_LANES) begin : g_bad_outputs
        $fatal(1, "c_gate_bus_split_v4_0: C_OUTPUTS must be 2..4");
    end

    localparam logic [NUM_LANES-1:0][C_WIDTH-1:0] MASKS = {
        parse_bits(C_OUTPUT_D_INV_MASK), parse_bits(C_OUTPUT_C_INV_MASK),
        parse_bits(C_OUTPUT_B_INV_MASK), parse_bits(C_OUTPUT_A_INV_MASK)};
    localparam logic [C_WIDTH-1:0] INIT = parse_bits(C_AINIT_VAL);
    localparam logic [1:0]         LAST = 2'(C_OUTPUTS - 1);

    logic                              ce, clr, accept;
    logic [1:0]                        ptr;
    logic [NUM_LANES-1:0]              ack, v, load;
    logic [NUM_LANES-1:0][C_WIDTH-1:0] q;
    logic                              unused_ok;

    assign ce  = (C_HAS_CE != 0)   ? CE   : 1'b1;
    // Without sync enable the clear overrides CE; with it, CE gates the clear.
    assign clr = ((C_HAS_SCLR != 0) ? SCLR : 1'b0) & ((C_SYNC_ENABLE != 0) ? ce : 1'b1);
    assign ack = {ACKD, ACKC, ACKB, ACKA};
    assign unused_ok = ^{CE, SCLR, ack};

    // Ack at the pointer frees the lane in the same cycle, so RFD follows ACK combinationally.
    assign RFD    = ce & (~v[ptr] | ack[ptr]);
    assign accept = ND & RFD;
    assign LANE   = ptr;

    // Round-robin pointer: advances only on an accepted word.
    always_ff @(posedge CLK or posedge ACLR) begin
        if (ACLR)                 ptr <= 2'd0;
        else if (clr)             ptr <= 2'd0;
        else if (accept)          ptr <= (ptr == LAST) ? 2'd0 : ptr + 2'd1;
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        if (k < C_OUTPUTS) begin : g_act
            assign load[k] = accept & (ptr == 2'(k));
            c_gate_bus_split_v4_0_lane #(
                .W(C_WIDTH), .MASK(MASKS[k]), .INIT(INIT)
            ) u_lane (
                .clk(CLK), .rst(ACLR), .clr(clr), .ce(ce),
                .load(load[k]), .ack(ack[k]), .d(D),
                .q(q[k]), .v(v[k])
            );
        end else begin : g_unused
            // Unused lanes never load and ignore acks.
            assign load[k] = 1'b0;
            assign q[k]    = INIT;
            assign v[k]    = 1'b0;
        end
    end

    assign {QD, QC, QB, QA} = q;
    assign {VD, VC, VB, VA} = v;
endmodule

// File: tb/tb_c_gate_bus_split_v4_0.sv
module tb_c_gate_bus_split_v4_0;
    typedef struct packed {
        logic [1:0]       ptr;
        logic [3:0]       v;
        logic [3:0][15:0] q;
    } mst_t;

    typedef struct {
        logic [63:0] q;
        logic [3:0]  v;
        logic [1:0]  lane;
    } exp_t;

    logic clk = 1'b0, aclr = 1'b0, ce = 1'b1, sclr = 1'b0, nd = 1'b0;
    logic [15:0] d = '0;
    logic [3:0]  ack = '0;
    logic        rfd_a, rfd_b, va_a, vb_a, vc_a, vd_a, va_b, vb_b, vc_b, vd_b;
    logic [15:0] qa_a, qb_a, qc_a, qd_a, qa_b, qb_b, qc_b, qd_b;
    logic [1:0]  lane_a, lane_b;

    int checks = 0, failures = 0;
    exp_t sb_a[$], sb_b[$];
    mst_t sa, sb;

    localparam logic [3:0][15:0] MASK_A = {16'h0000, 16'h0000, 16'hF0F0, 16'h0000};
    localparam logic [3:0][15:0] MASK_B = '0;
    localparam logic [15:0]      INIT_A = 16'hA5A5;
    localparam logic [15:0]      INIT_B = 16'h0000;

    always #5 clk = ~clk;

    c_gate_bus_split_v4_0 #(
        .C_WIDTH(16), .C_OUTPUTS(4),
        .C_OUTPUT_B_INV_MASK("1111000011110000"),
        .C_AINIT_VAL("1010010110100101"),
        .C_HAS_CE(1), .C_HAS_SCLR(1), .C_SYNC_ENABLE(0)
    ) dut_a (
        .CLK(clk), .ACLR(aclr), .CE(ce), .SCLR(sclr), .D(d), .ND(nd), .RFD(rfd_a),
        .QA(qa_a), .QB(qb_a), .QC(qc_a), .QD(qd_a),
        .VA(va_a), .VB(vb_a), .VC(vc_a), .VD(vd_a),
        .ACKA(ack[0]), .ACKB(ack[1]), .ACKC(ack[2]), .ACKD(ack[3]), .LANE(lane_a)
    );

    c_gate_bus_split_v4_0 #(
        .C_WIDTH(16), .C_OUTPUTS(2),
        .C_HAS_CE(1), .C_HAS_SCLR(1), .C_SYNC_ENABLE(1)
    ) dut_b (
        .CLK(clk), .ACLR(aclr), .CE(ce), .SCLR(sclr), .D(d), .ND(nd), .RFD(rfd_b),
        .QA(qa_b), .QB(qb_b), .QC(qc_b), .QD(qd_b),
        .VA(va_b), .VB(vb_b), .VC(vc_b), .VD(vd_b),
        .ACKA(ack[0]), .ACKB(ack[1]), .ACKC(ack[2]), .ACKD(ack[3]), .LANE(lane_b)
    );

    function automatic mst_t mreset(input logic [15:0] init);
        mst_t r;
        r.ptr = 2'd0;
        r.v   = 4'b0;
        r.q   = {4{init}};
        return r;
    endfunction

    function automatic logic mrfd(input mst_t s, input int n, input logic [3:0] ack_i, input logic ce_i);
        return ce_i && (!s.v[s.ptr] || (int'(s.ptr) < n && ack_i[s.ptr]));
    endfunction

    // Reference behaviour of one splitter for one clock edge.
    function automatic mst_t mstep(input mst_t s, input int n, input bit sync,
                                   input logic [3:0][15:0] mask, input logic [15:0] init,
                                   input logic nd_i, input logic [15:0] d_i,
                                   input logic [3:0] ack_i, input logic ce_i, input logic sclr_i);
        mst_t r;
        logic take;
        r = s;
        if (sync ? (sclr_i && ce_i) : sclr_i) begin
            r = mreset(init);
        end else if (ce_i) begin
            take = nd_i && mrfd(s, n, ack_i, ce_i);
            for (int k = 0; k < n; k++) if (ack_i[k]) r.v[k] = 1'b0;
            if (take) begin
                r.q[s.ptr] = d_i ^ mask[s.ptr];
                r.v[s.ptr] = 1'b1;
                r.ptr = (int'(s.ptr) == n - 1) ? 2'd0 : s.ptr + 2'd1;
            end
        end
        return r;
    endfunction

    function automatic exp_t to_exp(input mst_t s);
        exp_t e;
        e.q = s.q;
        e.v = s.v;
        e.lane = s.ptr;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pop one expected snapshot per DUT and compare against the live outputs.
    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb_a.size() == 0 || sb_b.size() == 0) begin
            checks++; failures++;
            $error("FAIL %s scoreboard_empty observed=0 expected=1", tag);
            return;
        end
        e = sb_a.pop_front();
        chk({tag, "/a_q"},    {qd_a, qc_a, qb_a, qa_a}, e.q);
        chk({tag, "/a_v"},    64'({vd_a, vc_a, vb_a, va_a}), 64'(e.v));
        chk({tag, "/a_lane"}, 64'(lane_a), 64'(e.lane));
        e = sb_b.pop_front();
        chk({tag, "/b_q"},    {qd_b, qc_b, qb_b, qa_b}, e.q);
        chk({tag, "/b_v"},    64'({vd_b, vc_b, vb_b, va_b}), 64'(e.v));
        chk({tag, "/b_lane"}, 64'(lane_b), 64'(e.lane));
    endtask

    // Drive one cycle of stimulus, check RFD before the edge, outputs after it.
    task automatic step(input string tag, input logic nd_i, input logic [15:0] d_i,
                        input logic [3:0] ack_i, input logic ce_i, input logic sclr_i);
        nd = nd_i; d = d_i; ack = ack_i; ce = ce_i; sclr = sclr_i;
        #1;
        chk({tag, "/a_rfd"}, 64'(rfd_a), 64'(mrfd(sa, 4, ack_i, ce_i)));
        chk({tag, "/b_rfd"}, 64'(rfd_b), 64'(mrfd(sb, 2, ack_i, ce_i)));
        sa = mstep(sa, 4, 1'b0, MASK_A, INIT_A, nd_i, d_i, ack_i, ce_i, sclr_i);
        sb = mstep(sb, 2, 1'b1, MASK_B, INIT_B, nd_i, d_i, ack_i, ce_i, sclr_i);
        sb_a.push_back(to_exp(sa));
        sb_b.push_back(to_exp(sb));
        @(posedge clk); #1;
        pop_cmp(tag);
        nd = 1'b0; ack = '0; sclr = 1'b0; ce = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        aclr = 1'b1;
        #12;
        aclr = 1'b0;
        sa = mreset(INIT_A);
        sb = mreset(INIT_B);
        @(posedge clk); #1;
        sb_a.push_back(to_exp(sa));
        sb_b.push_back(to_exp(sb));
        pop_cmp("reset");
        chk("reset/a_rfd", 64'(rfd_a), 64'd1);
        chk("reset/a_q_const", {qd_a, qc_a, qb_a, qa_a}, {4{16'hA5A5}});

        // Fill all four lanes; dut_b (2 lanes) stalls after two.
        step("fill0", 1'b1, 16'h1111, 4'b0000, 1'b1, 1'b0);
        step("fill1", 1'b1, 16'h2222, 4'b0000, 1'b1, 1'b0);
        step("fill2", 1'b1, 16'h3333, 4'b0000, 1'b1, 1'b0);
        step("fill3", 1'b1, 16'h4444, 4'b0000, 1'b1, 1'b0);
        chk("fill/a_q_const", {qd_a, qc_a, qb_a, qa_a}, {16'h4444, 16'h3333, 16'hD2D2, 16'h1111});
        chk("fill/a_lane_wrap", 64'(lane_a), 64'd0);

        // Fifth word blocked, then ACKA frees lane A in the same edge.
        step("stall", 1'b1, 16'h5555, 4'b0000, 1'b1, 1'b0);
        chk("stall/a_rfd_now", 64'(rfd_a), 64'd0);
        step("ack_load", 1'b1, 16'h5555, 4'b0001, 1'b1, 1'b0);
        chk("ack_load/a_qa", 64'(qa_a), 64'h5555);
        chk("ack_load/a_lane", 64'(lane_a), 64'd1);
        step("stall2", 1'b1, 16'h6666, 4'b0000, 1'b1, 1'b0);

        // Drain lane C, then a stray ACKC must change nothing.
        step("ackc", 1'b0, 16'h0000, 4'b0100, 1'b1, 1'b0);
        step("stray_c", 1'b0, 16'h0000, 4'b0100, 1'b1, 1'b0);
        step("stray_cd", 1'b0, 16'h0000, 4'b1100, 1'b1, 1'b0);

        // CE=0 freezes everything; clear with CE=0 only hits the non-sync-enable unit.
        step("ce_off", 1'b1, 16'h7777, 4'b1111, 1'b0, 1'b0);
        step("sclr_ce0", 1'b1, 16'h7777, 4'b0000, 1'b0, 1'b1);
        chk("sclr_ce0/a_qa_init", 64'(qa_a), 64'hA5A5);

        // Inversion on lane B.
        step("inv0", 1'b1, 16'h0000, 4'b0000, 1'b1, 1'b0);
        step("inv1", 1'b1, 16'h00FF, 4'b0000, 1'b1, 1'b0);
        chk("inv1/a_qb", 64'(qb_a), 64'hF00F);

        // Clear with CE=1 beats a simultaneous accept and ack.
        step("sclr_pri", 1'b1, 16'h8888, 4'b0011, 1'b1, 1'b1);

        // Async reset between edges with words held.
        step("pre_rst0", 1'b1, 16'h9999, 4'b0000, 1'b1, 1'b0);
        step("pre_rst1", 1'b1, 16'hAAAA, 4'b0000, 1'b1, 1'b0);
        #2;
        aclr = 1'b1;
        #1;
        sa = mreset(INIT_A);
        sb = mreset(INIT_B);
        sb_a.push_back(to_exp(sa));
        sb_b.push_back(to_exp(sb));
        pop_cmp("aclr_mid");
        chk("aclr_mid/a_rfd", 64'(rfd_a), 64'd1);
        #1;
        aclr = 1'b0;
        @(posedge clk); #1;

        // Random traffic against the model.
        for (int i = 0; i < 60; i++) begin
            step($sformatf("rnd%0d", i), 1'(($urandom % 4) != 0), 16'($urandom),
                 4'($urandom & $urandom), 1'(($urandom % 8) != 0), 1'(($urandom % 20) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
